// File: rtl/jtag_debug_host.sv
// JTAG debug host: takes a (virtual IR, DR word) command, walks the virtual
// JTAG sequence UIR -> CDR -> SDR -> UDR on a divided test clock, shifts the
// word out on tdi LSB first while capturing tdo, and returns the captured word.
//
//  state  | meaning
//  -------+-------------------------------------------------------------
//  IDLE   | run-test-idle, cmd_ready high, tck parked low
//  UIR    | one tck cycle, virtual IR update (ir_in loaded on entry)
//  CDR    | one tck cycle, capture-DR
//  SDR    | DR_LEN tck cycles, tdi driven / tdo sampled on tck rise
//  UDR    | one tck cycle, update-DR
//  FIN    | one clk settle after UDR's last high phase, tck low
//  RESP   | rsp_valid high until rsp_ready, rsp_data held
module jtag_debug_host #(
    parameter int TCK_DIV = 4,
    parameter int DR_LEN  = 38
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_ir,
    input  logic [DR_LEN-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DR_LEN-1:0] rsp_data,
    output logic              tck,
    output logic              tdi,
    input  logic              tdo,
    output logic [1:0]        ir_in,
    output logic              jtag_state_rti,
    output logic              vs_uir,
    output logic              vs_cdr,
    output logic              vs_sdr,
    output logic              vs_udr
);

    localparam int DW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam int BW = (DR_LEN > 1) ? $clog2(DR_LEN) : 1;
    localparam logic [DW-1:0] DIV_LOAD = DW'(TCK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DR_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UIR,
        S_CDR,
        S_SDR,
        S_UDR,
        S_FIN,
        S_RESP
    } state_t;

    state_t              state;
    logic [DW-1:0]       div_cnt;
    logic [BW-1:0]       bit_cnt;
    logic [DR_LEN-1:0]   shift_out;
    logic [DR_LEN-1:0]   shift_in;
    logic [4:0]          strobes;
    logic                tck_rise;
    logic                tck_end;

    // Strobe pattern {rti, uir, cdr, sdr, udr} for the state being entered.
    function automatic logic [4:0] strobes_for(input state_t s);
        case (s)
            S_UIR:   return 5'b01000;
            S_CDR:   return 5'b00100;
            S_SDR:   return 5'b00010;
            S_UDR:   return 5'b00001;
            default: return 5'b10000;
        endcase
    endfunction

    // Divider terminal count marks the last clk of a tck phase.
    always_comb begin
        tck_rise = ~tck & (div_cnt == '0);
        tck_end  = tck & (div_cnt == '0);
    end

    assign {jtag_state_rti, vs_uir, vs_cdr, vs_sdr, vs_udr} = strobes;

    // Sequencer, tck divider, serial shift paths and handshake outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            tck       <= 1'b0;
            tdi       <= 1'b0;
            ir_in     <= 2'b00;
            strobes   <= 5'b10000;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            shift_out <= '0;
            shift_in  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    tck     <= 1'b0;
                    tdi     <= 1'b0;
                    div_cnt <= '0;
                    if (cmd_valid && cmd_ready) begin
                        shift_out <= cmd_data;
                        ir_in     <= cmd_ir;
                        bit_cnt   <= '0;
                        div_cnt   <= DIV_LOAD;
                        cmd_ready <= 1'b0;
                        state     <= S_UIR;
                        strobes   <= strobes_for(S_UIR);
                    end
                end

                S_UIR, S_CDR, S_SDR, S_UDR: begin
                    // Down-count each half period; reload and flip tck at zero.
                    if (div_cnt == '0) begin
                        div_cnt <= DIV_LOAD;
                        tck     <= ~tck;
                    end else begin
                        div_cnt <= div_cnt - DW'(1);
                    end

                    // Capture on the clk edge that raises tck; first bit ends at bit 0.
                    if (tck_rise && state == S_SDR) begin
                        shift_in <= {tdo, shift_in[DR_LEN-1:1]};
                    end

                    // State changes only where a new tck low phase begins.
                    if (tck_end) begin
                        case (state)
                            S_UIR: begin
                                state   <= S_CDR;
                                strobes <= strobes_for(S_CDR);
                            end
                            S_CDR: begin
                                state     <= S_SDR;
                                strobes   <= strobes_for(S_SDR);
                                bit_cnt   <= '0;
                                tdi       <= shift_out[0];
                                shift_out <= shift_out >> 1;
                            end
                            S_SDR: begin
                                if (bit_cnt == BIT_LAST) begin
                                    state    <= S_UDR;
                                    strobes  <= strobes_for(S_UDR);
                                    tdi      <= 1'b0;
                                    rsp_data <= shift_in;
                                end else begin
                                    bit_cnt   <= bit_cnt + BW'(1);
                                    tdi       <= shift_out[0];
                                    shift_out <= shift_out >> 1;
                                end
                            end
                            default: begin
                                state   <= S_FIN;
                                strobes <= strobes_for(S_FIN);
                                tck     <= 1'b0;
                                div_cnt <= '0;
                            end
                        endcase
                    end
                end

                S_FIN: begin
                    tck       <= 1'b0;
                    div_cnt   <= '0;
                    rsp_valid <= 1'b1;
                    state     <= S_RESP;
                end

                S_RESP: begin
                    tck     <= 1'b0;
                    div_cnt <= '0;
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    state   <= S_IDLE;
                    strobes <= strobes_for(S_IDLE);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_debug_host.sv
// Bench for jtag_debug_host: two instances (TCK_DIV=4 and TCK_DIV=1), each with a
// timeline model that derives every output from the cycle offset since acceptance.
module tb_jtag_debug_host;

    localparam int DR = 38;

    logic clk;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int TD      = (g == 0) ? 4 : 1;
        localparam int N       = (DR + 3) * 2 * TD;
        localparam int LAT_LIT = (g == 0) ? 329 : 83;
        localparam int SDR_LIT = (g == 0) ? 304 : 76;
        localparam int TDI_LIT = (g == 0) ? 8 : 2;

        logic          reset_n, cmd_valid, cmd_ready, rsp_valid, rsp_ready;
        logic          tck, tdi, tdo, rti, vs_uir, vs_cdr, vs_sdr, vs_udr;
        logic          rnd_bit;
        logic [1:0]    cmd_ir, ir_in;
        logic [DR-1:0] cmd_data, rsp_data;
        int            tdo_sel;
        int            m_chk = 0, m_ok = 0, s_chk = 0, s_ok = 0;
        int            cnt_sdr = 0, cnt_tdi = 0, cnt_udr = 0;
        bit            done = 1'b0;

        assign tdo = (tdo_sel == 0) ? tdi : ((tdo_sel == 1) ? 1'b1 : rnd_bit);

        jtag_debug_host #(.TCK_DIV(TD), .DR_LEN(DR)) dut (
            .clk(clk), .reset_n(reset_n),
            .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
            .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
            .tck(tck), .tdi(tdi), .tdo(tdo), .ir_in(ir_in),
            .jtag_state_rti(rti), .vs_uir(vs_uir), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_udr(vs_udr)
        );

        initial begin
            rnd_bit = 1'b0;
            forever begin
                @(posedge clk);
                #1;
                rnd_bit = 1'($urandom);
            end
        end

        task automatic m_check(input string name, input logic [63:0] act, input logic [63:0] exp);
            m_chk++;
            if (act === exp) m_ok++;
            else $display("FAIL tdiv%0d %s at %0t: got %0h expected %0h", TD, name, $time, act, exp);
        endtask

        task automatic s_check(input string name, input logic [63:0] act, input logic [63:0] exp);
            s_chk++;
            if (act === exp) s_ok++;
            else $display("FAIL tdiv%0d %s at %0t: got %0h expected %0h", TD, name, $time, act, exp);
        endtask

        function automatic logic [DR-1:0] rnd_data();
            logic [63:0] r;
            r = {$urandom, $urandom};
            return r[DR-1:0];
        endfunction

        // Timeline model: k = clk edges since the acceptance edge (-1 when not busy).
        int            k = -1;
        bit            resp = 1'b0, known = 1'b0;
        logic [DR-1:0] dat_e = '0, samp = '0, rsp_e = '0;
        logic [1:0]    ir_e = 2'b00;
        logic [4:0]    e_str;
        logic          e_tck, e_tdi, e_rdy, e_rv;
        int            p, w, nk;

        always @(negedge clk) begin
            if (known) begin
                e_tck = 1'b0; e_tdi = 1'b0; e_str = 5'b10000; e_rdy = 1'b0; e_rv = 1'b0;
                if (resp) e_rv = 1'b1;
                else if (k < 0) e_rdy = 1'b1;
                else if (k < N) begin
                    p = k / (2 * TD);
                    w = k % (2 * TD);
                    e_tck = (w >= TD);
                    if (p == 0) e_str = 5'b01000;
                    else if (p == 1) e_str = 5'b00100;
                    else if (p < DR + 2) begin
                        e_str = 5'b00010;
                        e_tdi = dat_e[p-2];
                    end else e_str = 5'b00001;
                end
                m_check("strobes", 64'({rti, vs_uir, vs_cdr, vs_sdr, vs_udr}), 64'(e_str));
                m_check("tck", 64'(tck), 64'(e_tck));
                m_check("tdi", 64'(tdi), 64'(e_tdi));
                m_check("cmd_ready", 64'(cmd_ready), 64'(e_rdy));
                m_check("rsp_valid", 64'(rsp_valid), 64'(e_rv));
                m_check("ir_in", 64'(ir_in), 64'(ir_e));
                m_check("rsp_data", 64'(rsp_data), 64'(rsp_e));
                if (vs_sdr === 1'b1) cnt_sdr++;
                if (tdi === 1'b1) cnt_tdi++;
                if (vs_udr === 1'b1) cnt_udr++;
            end
            // Predict the effect of the coming rising edge from the current inputs.
            if (!reset_n) begin
                known = 1'b1; k = -1; resp = 1'b0; ir_e = 2'b00; rsp_e = '0;
            end else if (known) begin
                if (resp) begin
                    if (rsp_ready) resp = 1'b0;
                end else if (k < 0) begin
                    if (cmd_valid) begin
                        k = 0; dat_e = cmd_data; ir_e = cmd_ir; samp = '0;
                    end
                end else begin
                    nk = k + 1;
                    p = nk / (2 * TD);
                    w = nk % (2 * TD);
                    if (w == TD && p >= 2 && p < DR + 2) samp[p-2] = tdo;
                    if (nk == (DR + 2) * 2 * TD) rsp_e = samp;
                    if (nk == N + 1) begin
                        k = -1; resp = 1'b1;
                    end else k = nk;
                end
            end
        end

        // Issue one command and collect its response; keep=1 leaves cmd_valid high through RESP.
        task automatic run_cmd(input logic [1:0] ir, input logic [DR-1:0] data, input int stall,
                               input bit keep, output int lat, output logic [DR-1:0] rdat,
                               output logic [1:0] rir);
            int t;
            cmd_ir = ir; cmd_data = data; cmd_valid = 1'b1;
            t = 0;
            while (!cmd_ready && t < 3000) begin @(posedge clk); #1; t++; end
            s_check("accept_wait", 64'(cmd_ready), 64'(1));
            @(posedge clk); #1;
            if (!keep) cmd_valid = 1'b0;
            cmd_data = rnd_data();
            cmd_ir = 2'($urandom);
            lat = 0;
            while (!rsp_valid && lat < 3000) begin @(posedge clk); #1; lat++; end
            s_check("rsp_wait", 64'(rsp_valid), 64'(1));
            rdat = rsp_data;
            rir = ir_in;
            repeat (stall) begin @(posedge clk); #1; end
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
            if (keep) begin
                s_check("accept_first_idle", 64'(cmd_ready), 64'(1));
                @(posedge clk); #1;
                cmd_valid = 1'b0;
                s_check("accepted_in_idle", 64'(cmd_ready), 64'(0));
                t = 0;
                while (!rsp_valid && t < 3000) begin @(posedge clk); #1; t++; end
                s_check("kept_cmd_latency", 64'(t), 64'(LAT_LIT));
                rsp_ready = 1'b1;
                @(posedge clk); #1;
                rsp_ready = 1'b0;
            end
        endtask

        // Reset pulse in the high phase of SDR bit 10.
        task automatic reset_mid();
            int u0;
            bit seen;
            cmd_ir = 2'b10; cmd_data = rnd_data(); cmd_valid = 1'b1;
            u0 = 0;
            while (!cmd_ready && u0 < 3000) begin @(posedge clk); #1; u0++; end
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            u0 = cnt_udr;
            repeat (12 * 2 * TD + TD) begin @(posedge clk); #1; end
            s_check("in_sdr_bit10", 64'({vs_sdr, tck}), 64'(2'b11));
            reset_n = 1'b0;
            @(posedge clk); #1;
            reset_n = 1'b1;
            s_check("reset_abort", 64'({tck, rti, vs_sdr, rsp_valid}), 64'(4'b0100));
            seen = 1'b0;
            repeat (N + 20) begin
                @(posedge clk); #1;
                if (rsp_valid) seen = 1'b1;
            end
            s_check("abort_no_rsp", 64'(seen), 64'(0));
            s_check("abort_no_udr", 64'(cnt_udr - u0), 64'(0));
        endtask

        initial begin : stim
            int lat, c0, sel, st;
            logic [DR-1:0] rd, d;
            logic [1:0] ri, ir;
            reset_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
            cmd_ir = 2'b00; cmd_data = '0; tdo_sel = 0;
            repeat (3) @(posedge clk);
            #1;
            s_check("reset_state", 64'({tck, tdi, ir_in, rti, vs_uir, vs_cdr, vs_sdr, vs_udr,
                                        cmd_ready, rsp_valid}), 64'(11'b000_0100_0010));
            s_check("reset_rsp_data", 64'(rsp_data), 64'(0));
            reset_n = 1'b1;

            tdo_sel = 0;
            run_cmd(2'b01, 38'h2A_5555_5555, 0, 1'b0, lat, rd, ri);
            s_check("latency", 64'(lat), 64'(LAT_LIT));
            s_check("loop_data", 64'(rd), 64'(38'h2A_5555_5555));
            s_check("loop_ir", 64'(ri), 64'(2'b01));

            tdo_sel = 1;
            c0 = cnt_sdr;
            run_cmd(2'b10, rnd_data(), 2, 1'b0, lat, rd, ri);
            s_check("tdo_one_data", 64'(rd), 64'(38'h3F_FFFF_FFFF));
            s_check("sdr_cycles", 64'(cnt_sdr - c0), 64'(SDR_LIT));

            tdo_sel = 0;
            c0 = cnt_tdi;
            run_cmd(2'b11, 38'h1, 0, 1'b0, lat, rd, ri);
            s_check("tdi_high_cycles", 64'(cnt_tdi - c0), 64'(TDI_LIT));
            s_check("single_bit_data", 64'(rd), 64'(38'h1));
            s_check("single_bit_latency", 64'(lat), 64'(LAT_LIT));

            d = 38'h15_0F0F_33CC;
            run_cmd(2'b10, d, 20, 1'b1, lat, rd, ri);
            s_check("stall_data", 64'(rd), 64'(38'h15_0F0F_33CC));

            reset_mid();

            for (int i = 0; i < 6; i++) begin
                sel = $urandom_range(0, 2);
                st = $urandom_range(0, 4);
                ir = 2'($urandom);
                d = rnd_data();
                tdo_sel = sel;
                run_cmd(ir, d, st, 1'b0, lat, rd, ri);
                s_check("rand_latency", 64'(lat), 64'(LAT_LIT));
                s_check("rand_ir", 64'(ri), 64'(ir));
                if (sel == 0) s_check("rand_loop_data", 64'(rd), 64'(d));
            end
            done = 1'b1;
        end
    end

    initial begin : summary
        int cyc, t_chk, t_ok, pass_n, total_n;
        cyc = 0; t_chk = 0; t_ok = 0;
        while (!(u[0].done && u[1].done) && cyc < 60000) begin
            @(posedge clk);
            cyc++;
        end
        t_chk++;
        if (u[0].done && u[1].done) t_ok++;
        else $display("FAIL watchdog: runs finished %0d/%0d, required 2", 32'(u[0].done) + 32'(u[1].done), 2);
        repeat (2) @(posedge clk);
        pass_n  = t_ok + u[0].m_ok + u[0].s_ok + u[1].m_ok + u[1].s_ok;
        total_n = t_chk + u[0].m_chk + u[0].s_chk + u[1].m_chk + u[1].s_chk;
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
